// File: rtl/mbc_banked_if.sv
// Backing-store bus between the bank controller and the cartridge memory model.
// The controller drives address/select/strobes/write data; the store answers
// with mem_ready and mem_rdata.
interface mbc_banked_if #(
  parameter int ROM_BANK_BITS = 7,
  parameter int RAM_BANK_BITS = 2
);
  logic [ROM_BANK_BITS+13:0] rom_addr;
  logic [RAM_BANK_BITS+12:0] ram_addr;
  logic                      mem_sel;
  logic                      mem_read;
  logic                      mem_write;
  logic [7:0]                mem_wdata;
  logic                      mem_ready;
  logic [7:0]                mem_rdata;

  modport master (
    output rom_addr, ram_addr, mem_sel, mem_read, mem_write, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  rom_addr, ram_addr, mem_sel, mem_read, mem_write, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mbc_banked.sv
// Parametrised cartridge memory bank controller. Decodes CPU writes into the
// bank-control registers, maps CPU addresses onto ROM / external RAM, and runs
// one outstanding backing-store access at a time with a bounded wait.
module mbc_banked #(
  parameter int ROM_BANK_BITS = 7,
  parameter int RAM_BANK_BITS = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic              clock4,
  input  logic              reset,
  input  logic [15:0]       address,
  input  logic [7:0]        indata,
  input  logic              load,
  input  logic              store,
  output logic [7:0]        outdata,
  output logic              busy,
  output logic              error,
  mbc_banked_if.master      mem
);

  localparam int LO_BITS = (ROM_BANK_BITS < 5) ? ROM_BANK_BITS : 5;
  // The counter holds the cycles already waited, so the last permitted cycle
  // is TIMEOUT-1; firing there gives a strobe exactly TIMEOUT cycles wide.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ROM_RD,
    RAM_RD,
    RAM_WR
  } state_t;

  state_t state_q, state_d;

  // Bank-control registers
  logic               ram_en;
  logic [LO_BITS-1:0] bank_lo;
  logic [1:0]         bank_hi;
  logic               mode;

  // Access datapath registers
  logic [7:0]                wait_cnt;
  logic [ROM_BANK_BITS+13:0] rom_addr_q;
  logic [RAM_BANK_BITS+12:0] ram_addr_q;
  logic                      sel_q;
  logic [7:0]                wdata_q;

  // Decode / control strobes from the FSM
  logic                     is_low;
  logic                     is_ram;
  logic                     reg_wr;
  logic                     ram_off_rd;
  logic                     acc_done;
  logic                     acc_timeout;
  logic                     launch;
  logic [4:0]               lo_wr;
  logic [4:0]               lo_ext;
  logic [6:0]               bank_full;
  logic [ROM_BANK_BITS-1:0] rom_bank;
  logic [RAM_BANK_BITS-1:0] ram_bank;

  assign is_low = ~address[15];
  assign is_ram = (address[15:13] == 3'b101);

  // Zero check is on the full 5-bit field, before any truncation.
  assign lo_wr  = (indata[4:0] == 5'd0) ? 5'd1 : indata[4:0];
  assign lo_ext = 5'(bank_lo);

  assign bank_full = address[14] ? {bank_hi, lo_ext}
                                 : (mode ? {bank_hi, 5'b00000} : 7'd0);
  assign rom_bank  = bank_full[ROM_BANK_BITS-1:0];
  assign ram_bank  = mode ? bank_hi[RAM_BANK_BITS-1:0] : '0;

  assign launch = (state_q == IDLE) && (state_d != IDLE);

  // Next-state and per-cycle control decode
  always_comb begin
    state_d     = state_q;
    reg_wr      = 1'b0;
    ram_off_rd  = 1'b0;
    acc_done    = 1'b0;
    acc_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (store) begin
          if (is_low)
            reg_wr = 1'b1;
          else if (is_ram && ram_en)
            state_d = RAM_WR;
        end else if (load) begin
          if (is_low)
            state_d = ROM_RD;
          else if (is_ram) begin
            if (ram_en)
              state_d = RAM_RD;
            else
              ram_off_rd = 1'b1;
          end
        end
      end
      default: begin
        if (mem.mem_ready) begin
          state_d  = IDLE;
          acc_done = 1'b1;
        end else if (wait_cnt == TO_LAST) begin
          state_d     = IDLE;
          acc_timeout = 1'b1;
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock4) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Bank-control register writes from the CPU
  always_ff @(posedge clock4) begin
    if (reset) begin
      ram_en  <= 1'b0;
      bank_lo <= LO_BITS'(1);
      bank_hi <= 2'b00;
      mode    <= 1'b0;
    end else if (reg_wr) begin
      case (address[14:13])
        2'b00:   ram_en  <= (indata[3:0] == 4'hA);
        2'b01:   bank_lo <= lo_wr[LO_BITS-1:0];
        2'b10:   bank_hi <= indata[1:0];
        default: mode    <= indata[0];
      endcase
    end
  end

  // Address/data latch on entry and wait counter during an access
  always_ff @(posedge clock4) begin
    if (reset) begin
      wait_cnt   <= '0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      sel_q      <= 1'b0;
      wdata_q    <= '0;
    end else if (launch) begin
      wait_cnt <= '0;
      if (state_d == ROM_RD) begin
        sel_q      <= 1'b0;
        rom_addr_q <= {rom_bank, address[13:0]};
      end else begin
        sel_q      <= 1'b1;
        ram_addr_q <= {ram_bank, address[12:0]};
        if (state_d == RAM_WR)
          wdata_q <= indata;
      end
    end else if ((state_q != IDLE) && !acc_done && !acc_timeout) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Read data and sticky error
  always_ff @(posedge clock4) begin
    if (reset) begin
      outdata <= 8'hFF;
      error   <= 1'b0;
    end else begin
      if (ram_off_rd)
        outdata <= 8'hFF;
      if (acc_done && (state_q != RAM_WR))
        outdata <= mem.mem_rdata;
      if (acc_timeout) begin
        error <= 1'b1;
        if (state_q != RAM_WR)
          outdata <= 8'hFF;
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign mem.mem_read  = (state_q == ROM_RD) || (state_q == RAM_RD);
  assign mem.mem_write = (state_q == RAM_WR);
  assign mem.mem_sel   = sel_q;
  assign mem.rom_addr  = rom_addr_q;
  assign mem.ram_addr  = ram_addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mbc_banked.sv
// Directed bench for mbc_banked: ROM_BANK_BITS=7, RAM_BANK_BITS=2, TIMEOUT=4.
module tb_mbc_banked;

  logic        clk;
  logic        rst;
  logic [15:0] address;
  logic [7:0]  indata;
  logic        load;
  logic        store;
  logic [7:0]  outdata;
  logic        busy;
  logic        error;

  int passed;
  int total;

  mbc_banked_if #(.ROM_BANK_BITS(7), .RAM_BANK_BITS(2)) bus ();

  mbc_banked #(.ROM_BANK_BITS(7), .RAM_BANK_BITS(2), .TIMEOUT(4)) dut (
    .clock4  (clk),
    .reset   (rst),
    .address (address),
    .indata  (indata),
    .load    (load),
    .store   (store),
    .outdata (outdata),
    .busy    (busy),
    .error   (error),
    .mem     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic ld, input logic st, input logic [15:0] a, input logic [7:0] d);
    load = ld; store = st; address = a; indata = d;
    tick();
    load = 1'b0; store = 1'b0;
  endtask

  task automatic complete(input logic [7:0] rd);
    bus.mem_ready = 1'b1; bus.mem_rdata = rd;
    tick();
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (outdata !== 8'hFF) $display("FAIL reset_outdata: got %h expected %h", outdata, 8'hFF); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (error !== 1'b0) $display("FAIL reset_error: got %b expected 0", error); else passed++;
    total++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) $display("FAIL reset_strobes: got %b%b expected 00", bus.mem_read, bus.mem_write); else passed++;
    total++; if (bus.rom_addr !== 21'h0 || bus.ram_addr !== 15'h0) $display("FAIL reset_addr: got %h/%h expected 0/0", bus.rom_addr, bus.ram_addr); else passed++;
    total++; if (bus.mem_sel !== 1'b0 || bus.mem_wdata !== 8'h00) $display("FAIL reset_sel_wdata: got %b/%h expected 0/00", bus.mem_sel, bus.mem_wdata); else passed++;
  endtask

  task automatic test_rom_read();
    int hi;
    strobe(1'b1, 1'b0, 16'h4123, 8'h00);
    total++; if (bus.rom_addr !== 21'h004123) $display("FAIL rom_addr_bank1: got %h expected %h", bus.rom_addr, 21'h004123); else passed++;
    total++; if (busy !== 1'b1 || bus.mem_sel !== 1'b0) $display("FAIL rom_launch: got busy=%b sel=%b expected busy=1 sel=0", busy, bus.mem_sel); else passed++;
    hi = 0;
    for (int i = 0; i < 20 && bus.mem_read === 1'b1; i++) begin
      hi++;
      if (hi == 3) begin bus.mem_ready = 1'b1; bus.mem_rdata = 8'h5A; end
      tick();
    end
    bus.mem_ready = 1'b0;
    total++; if (hi != 3) $display("FAIL rom_read_width: got %0d expected 3", hi); else passed++;
    total++; if (outdata !== 8'h5A) $display("FAIL rom_read_data: got %h expected %h", outdata, 8'h5A); else passed++;
    total++; if (busy !== 1'b0 || error !== 1'b0) $display("FAIL rom_read_done: got busy=%b err=%b expected 0/0", busy, error); else passed++;
  endtask

  task automatic test_bank_lo();
    strobe(1'b0, 1'b1, 16'h2000, 8'h00);
    total++; if (busy !== 1'b0 || bus.mem_write !== 1'b0) $display("FAIL regwr_no_access: got busy=%b wr=%b expected 0/0", busy, bus.mem_write); else passed++;
    strobe(1'b1, 1'b0, 16'h4000, 8'h00);
    total++; if (bus.rom_addr !== 21'h004000) $display("FAIL bank_lo_zero: got %h expected %h", bus.rom_addr, 21'h004000); else passed++;
    complete(8'h01);
    strobe(1'b0, 1'b1, 16'h2000, 8'h20);
    strobe(1'b1, 1'b0, 16'h4000, 8'h00);
    total++; if (bus.rom_addr !== 21'h004000) $display("FAIL bank_lo_0x20: got %h expected %h", bus.rom_addr, 21'h004000); else passed++;
    complete(8'h02);
    strobe(1'b0, 1'b1, 16'h2000, 8'h07);
    strobe(1'b1, 1'b0, 16'h7FFF, 8'h00);
    total++; if (bus.rom_addr !== 21'h01FFFF) $display("FAIL bank_lo_7: got %h expected %h", bus.rom_addr, 21'h01FFFF); else passed++;
    complete(8'h22);
    total++; if (outdata !== 8'h22) $display("FAIL bank_lo_7_data: got %h expected %h", outdata, 8'h22); else passed++;
  endtask

  task automatic test_mode_banking();
    strobe(1'b0, 1'b1, 16'h4000, 8'h03);
    strobe(1'b0, 1'b1, 16'h6000, 8'h01);
    strobe(1'b1, 1'b0, 16'h0010, 8'h00);
    total++; if (bus.rom_addr !== 21'h180010) $display("FAIL mode1_low_rom: got %h expected %h", bus.rom_addr, 21'h180010); else passed++;
    complete(8'h10);
    strobe(1'b1, 1'b0, 16'h4000, 8'h00);
    total++; if (bus.rom_addr !== 21'h19C000) $display("FAIL mode1_high_rom: got %h expected %h", bus.rom_addr, 21'h19C000); else passed++;
    complete(8'h11);
    strobe(1'b0, 1'b1, 16'h0000, 8'h0A);
    strobe(1'b1, 1'b0, 16'hA005, 8'h00);
    total++; if (bus.ram_addr !== 15'h6005 || bus.mem_sel !== 1'b1) $display("FAIL ram_rd_addr: got %h sel=%b expected %h sel=1", bus.ram_addr, bus.mem_sel, 15'h6005); else passed++;
    total++; if (bus.mem_read !== 1'b1) $display("FAIL ram_rd_strobe: got %b expected 1", bus.mem_read); else passed++;
    complete(8'h3C);
    total++; if (outdata !== 8'h3C) $display("FAIL ram_rd_data: got %h expected %h", outdata, 8'h3C); else passed++;
  endtask

  task automatic test_ram_disabled();
    strobe(1'b0, 1'b1, 16'h0000, 8'h00);
    strobe(1'b1, 1'b0, 16'hA000, 8'h00);
    total++; if (outdata !== 8'hFF) $display("FAIL ram_off_read: got %h expected %h", outdata, 8'hFF); else passed++;
    total++; if (busy !== 1'b0 || bus.mem_read !== 1'b0) $display("FAIL ram_off_noaccess: got busy=%b rd=%b expected 0/0", busy, bus.mem_read); else passed++;
    strobe(1'b0, 1'b1, 16'hA001, 8'h55);
    total++; if (busy !== 1'b0 || bus.mem_write !== 1'b0) $display("FAIL ram_off_write: got busy=%b wr=%b expected 0/0", busy, bus.mem_write); else passed++;
    strobe(1'b0, 1'b1, 16'h0000, 8'h0A);
    strobe(1'b0, 1'b1, 16'hA001, 8'h99);
    total++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_sel !== 1'b1) $display("FAIL ram_wr_strobe: got wr=%b rd=%b sel=%b expected 1/0/1", bus.mem_write, bus.mem_read, bus.mem_sel); else passed++;
    total++; if (bus.mem_wdata !== 8'h99 || bus.ram_addr !== 15'h6001) $display("FAIL ram_wr_data: got %h@%h expected 99@6001", bus.mem_wdata, bus.ram_addr); else passed++;
    complete(8'h00);
    total++; if (bus.mem_write !== 1'b0 || busy !== 1'b0 || outdata !== 8'hFF) $display("FAIL ram_wr_done: got wr=%b busy=%b out=%h expected 0/0/ff", bus.mem_write, busy, outdata); else passed++;
  endtask

  task automatic test_timeout();
    int hi;
    strobe(1'b1, 1'b0, 16'h1234, 8'h00);
    complete(8'h11);
    bus.mem_ready = 1'b1; bus.mem_rdata = 8'h00;
    tick();
    bus.mem_ready = 1'b0;
    total++; if (outdata !== 8'h11 || busy !== 1'b0) $display("FAIL idle_ready_ignored: got out=%h busy=%b expected 11/0", outdata, busy); else passed++;
    strobe(1'b1, 1'b0, 16'h1234, 8'h00);
    hi = 0;
    for (int i = 0; i < 20 && bus.mem_read === 1'b1; i++) begin
      hi++;
      tick();
    end
    total++; if (hi != 4) $display("FAIL timeout_width: got %0d expected 4", hi); else passed++;
    total++; if (outdata !== 8'hFF || error !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_result: got out=%h err=%b busy=%b expected ff/1/0", outdata, error, busy); else passed++;
    strobe(1'b1, 1'b0, 16'h4000, 8'h00);
    complete(8'h42);
    total++; if (outdata !== 8'h42 || error !== 1'b1) $display("FAIL error_sticky: got out=%h err=%b expected 42/1", outdata, error); else passed++;
  endtask

  task automatic test_busy_ignore();
    strobe(1'b1, 1'b0, 16'h4000, 8'h00);
    strobe(1'b1, 1'b0, 16'h0010, 8'h00);
    total++; if (bus.rom_addr !== 21'h19C000 || bus.mem_read !== 1'b1) $display("FAIL busy_load_ignored: got %h rd=%b expected %h rd=1", bus.rom_addr, bus.mem_read, 21'h19C000); else passed++;
    strobe(1'b0, 1'b1, 16'h2000, 8'h02);
    complete(8'h33);
    total++; if (outdata !== 8'h33) $display("FAIL busy_read_data: got %h expected %h", outdata, 8'h33); else passed++;
    strobe(1'b1, 1'b0, 16'h4000, 8'h00);
    total++; if (bus.rom_addr !== 21'h19C000) $display("FAIL busy_regwr_ignored: got %h expected %h", bus.rom_addr, 21'h19C000); else passed++;
    complete(8'h34);
    strobe(1'b1, 1'b1, 16'h2000, 8'h05);
    total++; if (busy !== 1'b0 || bus.mem_read !== 1'b0) $display("FAIL both_regwr_noread: got busy=%b rd=%b expected 0/0", busy, bus.mem_read); else passed++;
    strobe(1'b1, 1'b0, 16'h4000, 8'h00);
    total++; if (bus.rom_addr !== 21'h194000) $display("FAIL both_regwr_applied: got %h expected %h", bus.rom_addr, 21'h194000); else passed++;
    complete(8'h5C);
    strobe(1'b1, 1'b1, 16'hA002, 8'h77);
    total++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_wdata !== 8'h77) $display("FAIL both_ram_store_wins: got wr=%b rd=%b d=%h expected 1/0/77", bus.mem_write, bus.mem_read, bus.mem_wdata); else passed++;
    complete(8'h00);
  endtask

  task automatic test_reset_mid();
    strobe(1'b1, 1'b0, 16'h4000, 8'h00);
    total++; if (bus.mem_read !== 1'b1) $display("FAIL mid_launch: got %b expected 1", bus.mem_read); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.mem_read !== 1'b0 || busy !== 1'b0) $display("FAIL mid_strobes: got rd=%b busy=%b expected 0/0", bus.mem_read, busy); else passed++;
    total++; if (outdata !== 8'hFF || error !== 1'b0) $display("FAIL mid_out_err: got out=%h err=%b expected ff/0", outdata, error); else passed++;
    total++; if (bus.rom_addr !== 21'h0 || bus.mem_sel !== 1'b0) $display("FAIL mid_addr: got %h sel=%b expected 0/0", bus.rom_addr, bus.mem_sel); else passed++;
    strobe(1'b1, 1'b0, 16'h4000, 8'h00);
    total++; if (bus.rom_addr !== 21'h004000) $display("FAIL mid_bank_reset: got %h expected %h", bus.rom_addr, 21'h004000); else passed++;
    complete(8'h01);
    strobe(1'b1, 1'b0, 16'h0010, 8'h00);
    total++; if (bus.rom_addr !== 21'h000010) $display("FAIL mid_mode_reset: got %h expected %h", bus.rom_addr, 21'h000010); else passed++;
    complete(8'h02);
    strobe(1'b1, 1'b0, 16'hA000, 8'h00);
    total++; if (bus.mem_read !== 1'b0 || outdata !== 8'hFF) $display("FAIL mid_ram_en_reset: got rd=%b out=%h expected 0/ff", bus.mem_read, outdata); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b1; load = 1'b0; store = 1'b0; address = 16'h0000; indata = 8'h00;
    bus.mem_ready = 1'b0; bus.mem_rdata = 8'h00;
    test_reset();
    test_rom_read();
    test_bank_lo();
    test_mode_banking();
    test_ram_disabled();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
